// File: rtl/fib_requester.sv
// fib_requester: issues one Fibonacci-core run per accepted index and returns result plus latency.
// Optional feature macro FIB_TIMEOUT_EN: WAIT gives up after TIMEOUT_CYCLES and flags rsp_timeout.
module fib_requester #(
  parameter int N_W            = 5,
  parameter int RES_W          = 128,
  parameter int START_GAP      = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [N_W-1:0]   req_n,
  output logic             core_start,
  output logic [N_W-1:0]   core_n,
  input  logic             core_finish,
  input  logic [RES_W-1:0] core_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N_W-1:0]   rsp_n,
  output logic [RES_W-1:0] rsp_result,
  output logic [15:0]      rsp_cycles,
  output logic             rsp_timeout
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_RESP, S_GAP} state_t;

`ifdef FIB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  state_t           state_q, state_d;
  logic             finish_q;
  logic [N_W-1:0]   core_n_q, core_n_d;
  logic [N_W-1:0]   rsp_n_q, rsp_n_d;
  logic [RES_W-1:0] rsp_result_q, rsp_result_d;
  logic [15:0]      rsp_cycles_q, rsp_cycles_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic [15:0]      gap_cnt_q, gap_cnt_d;
  logic [15:0]      cycles_inc;
  logic             finish_rise;
  logic             timeout_hit;
  logic             gap_done;

  // Only a fresh rising edge ends a run; a level left high by the previous run is ignored.
  assign finish_rise = core_finish && !finish_q;
  assign cycles_inc  = (rsp_cycles_q == 16'hFFFF) ? 16'hFFFF : rsp_cycles_q + 16'd1;
  assign timeout_hit = TIMEOUT_EN && (cycles_inc == 16'(TIMEOUT_CYCLES));
  assign gap_done    = (gap_cnt_q == 16'(START_GAP - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      finish_q      <= 1'b0;
      core_n_q      <= '0;
      rsp_n_q       <= '0;
      rsp_result_q  <= '0;
      rsp_cycles_q  <= '0;
      rsp_timeout_q <= 1'b0;
      gap_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      finish_q      <= core_finish;
      core_n_q      <= core_n_d;
      rsp_n_q       <= rsp_n_d;
      rsp_result_q  <= rsp_result_d;
      rsp_cycles_q  <= rsp_cycles_d;
      rsp_timeout_q <= rsp_timeout_d;
      gap_cnt_q     <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (finish_rise || timeout_hit) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = (START_GAP == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (gap_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    core_start = (state_q == S_START);
    rsp_valid  = (state_q == S_RESP);
  end

  always_comb begin
    core_n_d      = core_n_q;
    rsp_n_d       = rsp_n_q;
    rsp_result_d  = rsp_result_q;
    rsp_cycles_d  = rsp_cycles_q;
    rsp_timeout_d = rsp_timeout_q;
    gap_cnt_d     = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          core_n_d = req_n;
          rsp_n_d  = req_n;
        end
      end
      S_START: rsp_cycles_d = '0;
      S_WAIT: begin
        rsp_cycles_d = cycles_inc;
        // A finish edge wins over a timeout landing in the same cycle.
        if (finish_rise) begin
          rsp_result_d  = core_result;
          rsp_timeout_d = 1'b0;
        end else if (timeout_hit) begin
          rsp_result_d  = '0;
          rsp_timeout_d = 1'b1;
        end
      end
      S_RESP:  gap_cnt_d = '0;
      S_GAP:   gap_cnt_d = gap_cnt_q + 16'd1;
      default: ;
    endcase
  end

  assign core_n      = core_n_q;
  assign rsp_n       = rsp_n_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_cycles  = rsp_cycles_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_fib_requester.sv
// Directed bench for fib_requester with a behavioural core that finishes 12 cycles after start.
// Timeout scenario runs only when FIB_TIMEOUT_EN is defined.
module tb_fib_requester;

  localparam int N_W = 5;
  localparam int RES_W = 128;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [N_W-1:0]   req_n = '0;
  logic             core_start;
  logic [N_W-1:0]   core_n;
  logic             core_finish = 1'b0;
  logic [RES_W-1:0] core_result = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [N_W-1:0]   rsp_n;
  logic [RES_W-1:0] rsp_result;
  logic [15:0]      rsp_cycles;
  logic             rsp_timeout;

  int n_checks = 0;
  int n_pass = 0;
  int start_cnt = 0;
  int k = 0;
  logic run = 1'b0;
  logic core_hang = 1'b0;
  logic [N_W-1:0] mdl_n = '0;

  fib_requester #(
    .N_W(N_W), .RES_W(RES_W), .START_GAP(2), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n),
    .core_start(core_start), .core_n(core_n),
    .core_finish(core_finish), .core_result(core_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_n(rsp_n), .rsp_result(rsp_result),
    .rsp_cycles(rsp_cycles), .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [RES_W-1:0] fib(input logic [N_W-1:0] n);
    logic [RES_W-1:0] a, b, t;
    a = '0;
    b = 128'd1;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Core model: finish stays at its old level for one cycle, drops, then rises 12 cycles after start.
  always @(posedge clk) begin
    if (core_start) begin
      start_cnt <= start_cnt + 1;
      k <= 1;
      run <= 1'b1;
      mdl_n <= core_n;
    end else if (run) begin
      k <= k + 1;
      if (k == 1) core_finish <= 1'b0;
      if (k == 11 && !core_hang) begin
        core_finish <= 1'b1;
        core_result <= fib(mdl_n);
        run <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [RES_W-1:0] obs, input logic [RES_W-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic do_req(input logic [N_W-1:0] n);
    int i;
    i = 0;
    while (!req_ready && i < 50) begin
      @(negedge clk);
      i++;
    end
    check("req_ready_wait", req_ready, 1'b1);
    req_n = n;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("core_start_pulse", core_start, 1'b1);
    check("core_n", core_n, n);
    check("req_ready_busy", req_ready, 1'b0);
    @(posedge clk);
    #1;
    check("core_start_single", core_start, 1'b0);
    check("core_n_hold", core_n, n);
  endtask

  task automatic wait_rsp(input int max_cyc);
    int i;
    i = 0;
    while (!rsp_valid && i < max_cyc) begin
      @(negedge clk);
      i++;
    end
    check("rsp_valid_wait", rsp_valid, 1'b1);
    $display("rsp n=%0d result=%0d cycles=%0d timeout=%0b", rsp_n, rsp_result, rsp_cycles, rsp_timeout);
  endtask

  task automatic expect_rsp(input logic [N_W-1:0] n, input logic [RES_W-1:0] res, input logic [15:0] cyc);
    check("rsp_n", rsp_n, n);
    check("rsp_result", rsp_result, res);
    check("rsp_cycles", rsp_cycles, cyc);
    check("rsp_timeout", rsp_timeout, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit stable;
    bit saw_valid;

    // Reset values
    #1;
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_core_start", core_start, 1'b0);
    check("rst_core_n", core_n, '0);
    check("rst_rsp_result", rsp_result, '0);
    check("rst_rsp_cycles", rsp_cycles, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_req_ready", req_ready, 1'b1);

    // n=10 with consumer always ready
    rsp_ready = 1'b1;
    base = start_cnt;
    do_req(5'd10);
    wait_rsp(40);
    expect_rsp(5'd10, 128'd55, 16'd12);
    @(posedge clk);
    #1;
    check("rsp_valid_drop", rsp_valid, 1'b0);
    check("start_count", 128'(start_cnt - base), 128'd1);

    // Back-to-back n=0 then n=1, finish held high between runs
    do_req(5'd0);
    wait_rsp(40);
    expect_rsp(5'd0, 128'd0, 16'd12);
    do_req(5'd1);
    wait_rsp(40);
    expect_rsp(5'd1, 128'd1, 16'd12);
    @(posedge clk);
    #1;

    // n=20 with response backpressure for 20 cycles
    rsp_ready = 1'b0;
    do_req(5'd20);
    wait_rsp(40);
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!rsp_valid || rsp_result !== 128'd6765 || rsp_n !== 5'd20 || rsp_cycles !== 16'd12)
        stable = 1'b0;
    end
    check("bp_stable", stable, 1'b1);
    check("bp_result", rsp_result, 128'd6765);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_valid_drop", rsp_valid, 1'b0);
    check("gap1_req_ready", req_ready, 1'b0);
    @(posedge clk);
    #1;
    check("gap2_req_ready", req_ready, 1'b0);
    @(posedge clk);
    #1;
    check("gap_end_req_ready", req_ready, 1'b1);

`ifdef FIB_TIMEOUT_EN
    // Core never finishes: timeout at 50 WAIT cycles
    core_hang = 1'b1;
    do_req(5'd7);
    wait_rsp(100);
    check("to_flag", rsp_timeout, 1'b1);
    check("to_result", rsp_result, '0);
    check("to_cycles", rsp_cycles, 16'd50);
    @(posedge clk);
    #1;
    core_hang = 1'b0;
`endif

    // Reset in WAIT on n=30, then a fresh n=5 request
    do_req(5'd30);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_rsp_n", rsp_n, '0);
    check("mid_rst_core_n", core_n, '0);
    check("mid_rst_rsp_result", rsp_result, '0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_req_ready", req_ready, 1'b1);
    check("post_rst_rsp_valid", rsp_valid, 1'b0);
    check("post_rst_core_start", core_start, 1'b0);
    check("post_rst_rsp_cycles", rsp_cycles, '0);
    check("post_rst_rsp_timeout", rsp_timeout, 1'b0);
    saw_valid = 1'b0;
    for (int i = 0; i < 20 && !core_finish; i++) begin
      @(negedge clk);
      if (rsp_valid) saw_valid = 1'b1;
    end
    check("stale_finish_high", core_finish, 1'b1);
    check("abandoned_no_rsp", saw_valid, 1'b0);
    do_req(5'd5);
    wait_rsp(40);
    expect_rsp(5'd5, 128'd5, 16'd12);
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fib_requester.md
FIB_REQUESTER -- requirements
Module: fib_requester

Interface
REQ-001 SHALL have parameters: N_W, default 5, core index width; RES_W, default 128, result width; START_GAP, default 2, idle cycles after each response before the next request is accepted; TIMEOUT_CYCLES, default 1023, WAIT-state limit used only under FIB_TIMEOUT_EN.
REQ-002 SHALL have port clk, input, 1, sole clock; all state changes occur on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1, request index present.
REQ-005 SHALL have port req_ready, output, 1, requester can accept an index.
REQ-006 SHALL have port req_n, input, N_W, requested Fibonacci index.
REQ-007 SHALL have port core_start, output, 1, one-cycle start pulse to the fibonacci core.
REQ-008 SHALL have port core_n, output, N_W, index driven to the core.
REQ-009 SHALL have port core_finish, input, 1, core done flag; the core may hold it high.
REQ-010 SHALL have port core_result, input, RES_W, core result.
REQ-011 SHALL have port rsp_valid, output, 1, response available.
REQ-012 SHALL have port rsp_ready, input, 1, consumer accepts the response.
REQ-013 SHALL have ports rsp_n (N_W) and rsp_result (RES_W), outputs, echoed index and captured result.
REQ-014 SHALL have ports rsp_cycles, output, 16, start-to-finish latency; and rsp_timeout, output, 1, timeout flag.

Function
REQ-015 SHALL implement the FSM states IDLE, START, WAIT, RESP and GAP.
REQ-016 IDLE SHALL drive req_ready=1 and SHALL leave on req_valid&&req_ready, latching req_n into core_n and rsp_n; next state START.
REQ-017 START SHALL assert core_start for exactly one cycle and then go to WAIT; req_ready SHALL be 0 in every state except IDLE.
REQ-018 core_n SHALL hold stable from START until the next accepted request.
REQ-019 finish detection SHALL use the rising edge of core_finish (registered finish_q); a level held high from the previous run SHALL NOT complete the current run.
REQ-020 A rising edge detected in WAIT SHALL capture core_result into rsp_result in that cycle, and the FSM SHALL go to RESP.
REQ-021 rsp_cycles SHALL clear in START, increment each WAIT cycle, and saturate at 16'hFFFF.
REQ-022 RESP SHALL hold rsp_valid=1 with stable rsp_* until rsp_ready=1, then go to GAP; rsp_valid SHALL drop the cycle after the handshake.
REQ-023 GAP SHALL last exactly START_GAP cycles, then go to IDLE; START_GAP=0 SHALL go directly to IDLE.
REQ-024 rsp_n, rsp_result, rsp_cycles and rsp_timeout SHALL keep their last values outside RESP.
REQ-025 A rising edge of core_finish outside WAIT SHALL be ignored.
REQ-026 Minimum latency SHALL be: request accept -> core_start 1 cycle; finish edge -> rsp_valid 1 cycle.

Reset
REQ-027 rst low SHALL asynchronously force state IDLE and finish_q=0.
REQ-028 Reset SHALL force all outputs to 0 except req_ready, which is 1 after reset release.
REQ-029 Reset mid-operation (any state) SHALL abandon the run with no response; a core_finish still high after release SHALL NOT be counted, per REQ-019.

Configuration
REQ-030 With FIB_TIMEOUT_EN defined, WAIT SHALL exit to RESP when rsp_cycles reaches TIMEOUT_CYCLES without a finish edge, with rsp_timeout=1 and rsp_result=0; a finish edge in the same cycle SHALL take priority, giving rsp_timeout=0.
REQ-031 Without FIB_TIMEOUT_EN, WAIT SHALL wait indefinitely, and rsp_timeout SHALL be constant 0.

Verification
REQ-032 The bench SHALL use a core model that raises core_finish 12 cycles after core_start, holds it high, and returns F(n) with F(0)=0.
REQ-033 Scenario: req_n=10, rsp_ready=1 -> one core_start pulse, core_n=10, rsp_result=55, rsp_n=10, rsp_cycles=12, rsp_timeout=0.
REQ-034 Scenario: back-to-back requests n=0 then n=1 with core_finish held high between runs -> responses 0 then 1, and the second completes only on its own finish edge.
REQ-035 Scenario: rsp_ready held 0 for 20 cycles after rsp_valid with n=20 -> rsp_valid and rsp_result=6765 stable throughout; req_ready=1 exactly START_GAP=2 cycles after the handshake.
REQ-036 Scenario: FIB_TIMEOUT_EN, TIMEOUT_CYCLES=50, core never finishes -> rsp_valid at cycle 50 of WAIT with rsp_timeout=1, rsp_result=0, rsp_cycles=50.
REQ-037 Scenario: rst low for 1 cycle in WAIT on n=30 -> all outputs 0, req_ready=1 after release; a fresh n=5 request returns 5.
